uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 16: maximum cycles to wait for tx_bussy to rise after tx_start.
REQ-002 Parameter LOCK_MAX, default 16: maximum consecutive bytes one requester may send under lock (UART_ARB_LOCK_EN only).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  4  per-requester byte-available flag.
REQ-006 req_data  input  32  four bytes; requester i uses bits [8i+7:8i].
REQ-007 req_lock  input  4  per-requester hold-grant request; present only with UART_ARB_LOCK_EN.
REQ-008 req_ready  output  4  one-hot accept pulse; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 tx_start  output  1  single-cycle start strobe to the UART transmitter.
REQ-010 tx_data  output  8  byte presented to the transmitter; stable from tx_start until return to IDLE.
REQ-011 tx_bussy  input  1  transmitter busy flag; high for the whole frame.
REQ-012 grant  output  2  index of the current or last-served requester.
REQ-013 tx_err  output  1  single-cycle pulse on busy timeout.

Function
REQ-014 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: when tx_bussy is low and any req_valid is high, select the winner by round-robin starting at grant+1 modulo 4; assert req_ready[winner] in the same cycle; latch req_data of the winner into tx_data; update grant; go to START.
REQ-016 IDLE with tx_bussy high or no req_valid: hold state; req_ready is 0.
REQ-017 START: tx_start = 1 for exactly one cycle; go to WAIT_BUSY; latency from accept to tx_start is 1 cycle.
REQ-018 WAIT_BUSY: go to WAIT_DONE on tx_bussy high; if BUSY_TIMEOUT cycles elapse without tx_bussy, pulse tx_err for one cycle and go to IDLE.
REQ-019 WAIT_DONE: go to IDLE on the first cycle tx_bussy is low.
REQ-020 At most one req_ready bit is high in any cycle; req_ready is never high outside IDLE.
REQ-021 Round-robin wrap: a search from grant = 3 starts at 0. All four requesters valid with no lock: grant sequence is 0,1,2,3,0.
REQ-022 The timeout counter is width ceil(log2(BUSY_TIMEOUT+1)); it clears on entry to WAIT_BUSY and saturates.
REQ-023 A requester dropping req_valid outside its accept cycle has no effect; no byte is lost or duplicated.

Reset
REQ-024 On rst high at any clock, including mid-frame: state = IDLE; tx_start = 0; req_ready = 0; tx_data = 0x00; grant = 3 (so requester 0 has first priority); tx_err = 0; counters = 0.
REQ-025 After reset release, the first arbitration can occur in the first cycle rst is low.

Configuration
REQ-026 Macro UART_ARB_LOCK_EN. When defined: in IDLE, if req_lock[grant] and req_valid[grant] are high and the lock count is below LOCK_MAX, re-grant the same requester and bypass rotation. The lock count increments per locked byte, clears on any rotation, and at LOCK_MAX rotation is forced. When undefined: the req_lock port and lock counter are absent, and arbitration is pure round-robin.

Structure
REQ-027 Shared package uart_pkg holds the FSM state encoding, N_REQ = 4 and the default BUSY_TIMEOUT and LOCK_MAX constants.
REQ-028 One sub-module, rr_pick: combinational 4-way round-robin priority picker (inputs: request vector, last grant; outputs: winner index, any).

Verification
REQ-029 Reset, then req_valid = 0001, data 0x41, and tx_bussy rising 2 cycles after tx_start for 10 cycles -> req_ready = 0001 for one cycle, tx_start the next cycle, tx_data = 0x41, grant = 0, return to IDLE.
REQ-030 req_valid = 1111 held, model transmitter answering every start -> grants 0,1,2,3,0 in order, with one req_ready pulse per frame.
REQ-031 tx_bussy held 0 after tx_start -> tx_err pulses exactly BUSY_TIMEOUT cycles after entry to WAIT_BUSY; FSM returns to IDLE.
REQ-032 rst asserted during WAIT_DONE -> all outputs return to their reset values next cycle; the next accept goes to requester 0.
REQ-033 UART_ARB_LOCK_EN, req_lock = 0010, req_valid = 0011 -> 16 consecutive grants to requester 1, then grant 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, requester count,
// default timing limits and the round-robin index helper.
package uart_pkg;

  localparam int N_REQ            = 4;
  localparam int IDX_W            = $clog2(N_REQ);
  localparam int BUSY_TIMEOUT_DEF = 16;
  localparam int LOCK_MAX_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Wraps modulo N_REQ through truncation; N_REQ is a power of two.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int unsigned     off);
    return base + IDX_W'(off);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches the request vector starting one
// past the last grant and returns the first requester found.
module rr_pick
  import uart_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  always_comb begin
    winner_o = last_i;
    any_o    = 1'b0;
    // Offset N_REQ lands back on last_i, so a lone requester can win repeatedly.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!any_o && req_i[rr_idx(last_i, k)]) begin
        winner_o = rr_idx(last_i, k);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter feeding one UART transmitter, with busy-handshake
// timeout. Optional grant locking is compiled in with UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int LOCK_MAX     = LOCK_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]     req_lock,
`endif
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_bussy,
  output logic [IDX_W-1:0]     grant,
  output logic                 tx_err
);

  localparam int              CNT_W       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(BUSY_TIMEOUT);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_winner, winner;
  logic             rr_any;

  rr_pick u_rr_pick (
    .req_i    (req_valid),
    .last_i   (grant_q),
    .winner_o (rr_winner),
    .any_o    (rr_any)
  );

`ifdef UART_ARB_LOCK_EN
  localparam int               LOCK_W    = $clog2(LOCK_MAX + 1);
  // The byte won by rotation opens the run, so re-grants stop one short of LOCK_MAX.
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              hold;

  assign hold   = req_lock[grant_q] && req_valid[grant_q] && (lock_cnt_q < LOCK_LAST);
  assign winner = hold ? grant_q : rr_winner;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == ST_IDLE && req_ready != '0) begin
      lock_cnt_d = hold ? lock_cnt_q + LOCK_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lock_cnt_q <= '0;
    else     lock_cnt_q <= lock_cnt_d;
  end
`else
  assign winner = rr_winner;

  // LOCK_MAX only shapes the lock build; this keeps it elaborated in every build.
  if (LOCK_MAX < 1) begin : g_lock_max_invalid
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    tx_start  = 1'b0;
    tx_err    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!tx_bussy && rr_any) begin
          req_ready[winner] = 1'b1;
          data_d            = req_data[{winner, 3'b000} +: 8];
          grant_d           = winner;
          state_d           = ST_START;
        end
      end
      ST_START: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_bussy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          tx_err  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_bussy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes stay quiet during a reset cycle so nothing is accepted and then discarded.
    if (rst) begin
      req_ready = '0;
      tx_start  = 1'b0;
      tx_err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= IDX_W'(N_REQ - 1);
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_data = data_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, timeout and
// mid-frame reset sequences, then random traffic against a frame-level model.
module tb_uart_tx_arbiter;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]  req_lock = '0;
`endif
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_bussy = 1'b0;
  logic [1:0]  grant;
  logic        tx_err;

  int checks = 0;
  int errors = 0;

  // Transmitter model knobs and state
  bit xmit_en = 1'b1;
  bit xmit_rand = 1'b0;
  bit busy_hold = 1'b0;
  int xmit_delay = 2;
  int xmit_len = 10;
  bit start_flag = 1'b0;
  bit armed = 1'b0;
  int wait_n = 0;
  int left = 0;
  int cur_len = 0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    int          w0;
    int          w1;
    int          w2;
  } vec_t;

  vec_t tbl[7];

  uart_tx_arbiter #(.BUSY_TIMEOUT(T), .LOCK_MAX(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_bussy  (tx_bussy),
    .grant     (grant),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    start_flag = tx_start;
  end

  // Transmitter: busy rises D cycles after the start strobe and stays high L cycles.
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      armed = 1'b0;
      left  = 0;
      wait_n = 0;
    end else begin
      if (start_flag && xmit_en) begin
        armed   = 1'b1;
        wait_n  = xmit_rand ? int'($urandom_range(0, 2)) : xmit_delay - 1;
        cur_len = xmit_rand ? int'($urandom_range(1, 6)) : xmit_len;
      end else if (armed && wait_n > 0) begin
        wait_n--;
      end
      if (armed && wait_n == 0) begin
        armed = 1'b0;
        left  = cur_len;
      end
    end
    tx_bussy = busy_hold || (left > 0);
    if (left > 0) left--;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    busy_hold = 1'b0;
`ifdef UART_ARB_LOCK_EN
    req_lock = '0;
`endif
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  function automatic int rr_ref(input int last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Offers v/d until accepted, then runs the frame to completion; returns winner.
  task automatic do_frame(input logic [3:0] v, input logic [31:0] d, output int w);
    int n;
    bit seen;
    w = -1;
    req_valid = v;
    req_data  = d;
    smp();
    n = 0;
    while (req_ready == 4'b0000 && n < 60) begin
      cyc();
      smp();
      n++;
    end
    chk("accept_seen", 32'(req_ready != 4'b0000), 32'd1);
    if (req_ready == 4'b0000) return;
    chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
    for (int i = 0; i < 4; i++) if (req_ready[i]) w = i;
    cyc();
    req_valid = '0;
    smp();
    chk("tx_start", 32'(tx_start), 32'd1);
    chk("ready_after_accept", 32'(req_ready), 32'd0);
    chk("tx_data", 32'(tx_data), 32'(d[8*w +: 8]));
    chk("grant", 32'(grant), 32'(w));
    seen = 1'b0;
    n = 0;
    while (!(seen && !tx_bussy) && n < 80) begin
      cyc();
      smp();
      if (tx_bussy) seen = 1'b1;
      chk("ready_in_frame", 32'(req_ready), 32'd0);
      n++;
    end
    chk("frame_done", 32'(seen && !tx_bussy), 32'd1);
    cyc();
  endtask

  initial begin
    int w;
    int exp;
    bit m_idle;
    bit m_start_due;
    bit m_in_frame;
    bit m_seen_busy;
    int m_last;
    logic [7:0] m_data;
    logic [3:0] exp_ready;

    tbl[0] = '{4'b0001, 32'h00000041, 0, 0, 0};
    tbl[1] = '{4'b0100, 32'h00C30000, 2, 2, 2};
    tbl[2] = '{4'b1000, 32'hA5000000, 3, 3, 3};
    tbl[3] = '{4'b0110, 32'h00776600, 1, 2, 1};
    tbl[4] = '{4'b1010, 32'h88007700, 1, 3, 1};
    tbl[5] = '{4'b1001, 32'h1E00002D, 0, 3, 0};
    tbl[6] = '{4'b1111, 32'h44332211, 0, 1, 2};

    // Reset values, then first arbitration on the first cycle out of reset
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 32'h44332211;
    cyc();
    smp();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    cyc();
    rst = 1'b0;
    smp();
    chk("first_arb_ready", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;

    // Directed round-robin vectors
    for (int e = 0; e < 7; e++) begin
      apply_reset();
      for (int f = 0; f < 3; f++) begin
        do_frame(tbl[e].v, tbl[e].d, w);
        exp = (f == 0) ? tbl[e].w0 : (f == 1) ? tbl[e].w1 : tbl[e].w2;
        chk($sformatf("tbl%0d_frame%0d_winner", e, f), 32'(w), 32'(exp));
      end
    end

    // All four valid: 0,1,2,3,0 with a varying transmitter
    apply_reset();
    xmit_rand = 1'b1;
    for (int f = 0; f < 5; f++) begin
      do_frame(4'b1111, 32'hD4C3B2A1, w);
      chk("rr_all_valid", 32'(w), 32'(f % 4));
    end
    xmit_rand = 1'b0;

    // Busy transmitter blocks arbitration in IDLE
    apply_reset();
    busy_hold = 1'b1;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("busy_blocks_accept", 32'(req_ready), 32'd0);
      cyc();
    end
    busy_hold = 1'b0;
    smp();
    chk("accept_after_busy", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;

    // Busy timeout
    apply_reset();
    xmit_en = 1'b0;
    req_valid = 4'b0001;
    req_data = 32'h0000005A;
    smp();
    chk("to_accept", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;
    smp();
    chk("to_start", 32'(tx_start), 32'd1);
    for (int k = 1; k <= T + 1; k++) begin
      cyc();
      smp();
      chk($sformatf("tx_err_cycle%0d", k), 32'(tx_err), 32'(k == T + 1));
    end
    cyc();
    req_valid = 4'b0100;
    smp();
    chk("idle_after_timeout", 32'(req_ready), 32'b0100);
    chk("tx_err_single", 32'(tx_err), 32'd0);
    cyc();
    xmit_en = 1'b1;

    // Reset during WAIT_DONE
    apply_reset();
    xmit_delay = 1;
    xmit_len = 30;
    req_valid = 4'b0010;
    req_data = 32'h00007E00;
    smp();
    chk("mr_accept", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = '0;
    smp();
    for (int n = 0; n < 10 && !tx_bussy; n++) begin
      cyc();
      smp();
    end
    chk("mr_busy_seen", 32'(tx_bussy), 32'd1);
    cyc();
    smp();
    cyc();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 32'h44332211;
    smp();
    chk("mr_ready_in_rst", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0;
    smp();
    chk("mr_tx_start", 32'(tx_start), 32'd0);
    chk("mr_tx_data", 32'(tx_data), 32'd0);
    chk("mr_grant", 32'(grant), 32'd3);
    chk("mr_tx_err", 32'(tx_err), 32'd0);
    chk("mr_next_accept", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;
    xmit_delay = 2;
    xmit_len = 10;

`ifdef UART_ARB_LOCK_EN
    apply_reset();
    req_lock = 4'b0010;
    for (int f = 0; f < 18; f++) begin
      do_frame(4'b0011, 32'h00002211, w);
      chk("lock_seq", 32'(w), 32'((f == 0 || f == 17) ? 0 : 1));
    end
    req_lock = '0;
`endif

    // Random traffic against a frame-level model
    apply_reset();
    xmit_rand = 1'b1;
    m_idle = 1'b1;
    m_start_due = 1'b0;
    m_in_frame = 1'b0;
    m_seen_busy = 1'b0;
    m_last = 3;
    m_data = 8'h00;
    for (int c = 0; c < 800; c++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      req_data  = $urandom();
      smp();
      exp_ready = '0;
      w = -1;
      if (m_idle && !tx_bussy && req_valid != 4'b0000) begin
        w = rr_ref(m_last, req_valid);
        exp_ready[w] = 1'b1;
      end
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_start", 32'(tx_start), 32'(m_start_due));
      chk("rnd_data", 32'(tx_data), 32'(m_data));
      chk("rnd_grant", 32'(grant), 32'(m_last));
      chk("rnd_err", 32'(tx_err), 32'd0);
      if (w >= 0) begin
        m_last = w;
        m_data = req_data[8*w +: 8];
        m_idle = 1'b0;
        m_in_frame = 1'b0;
        m_seen_busy = 1'b0;
        m_start_due = 1'b1;
      end else if (m_start_due) begin
        m_start_due = 1'b0;
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        if (tx_bussy) begin
          m_seen_busy = 1'b1;
        end else if (m_seen_busy) begin
          m_in_frame = 1'b0;
          m_idle = 1'b1;
        end
      end
      cyc();
    end
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
